// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder slices.
package cla_pkg;
    localparam int CLA_W_DEFAULT = 8;
    localparam int CLA_W_MAX     = 16;
endpackage

// File: rtl/cla_carry_net.sv
// Flat sum-of-products carry network: every carry is computed directly from Gs/Ps/Cin.
// Optional group generate/propagate outputs under CLA_GROUP_PG_EN.
module cla_carry_net
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_W_DEFAULT
) (
    input  logic [WIDTH-1:0] Gs,
    input  logic [WIDTH-1:0] Ps,
    input  logic             Cin,
    output logic [WIDTH:0]   C
`ifdef CLA_GROUP_PG_EN
    ,
    output logic             GG,
    output logic             PG
`endif
);

    logic sop;
    logic prod;

    // c(i+1) = OR over j of Gs[j]&Ps[j+1..i], plus Cin&Ps[0..i]; loops unroll into flat AND-OR terms
    always_comb begin
        C    = '0;
        sop  = 1'b0;
        prod = 1'b0;
        C[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            sop = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod = Gs[j];
                for (int k = j + 1; k <= i; k++) prod = prod & Ps[k];
                sop = sop | prod;
            end
            prod = Cin;
            for (int k = 0; k <= i; k++) prod = prod & Ps[k];
            C[i+1] = sop | prod;
        end
    end

`ifdef CLA_GROUP_PG_EN
    logic g_sop;
    logic g_prod;

    // Group generate is the carry-out with Cin forced to 0
    always_comb begin
        g_sop  = 1'b0;
        g_prod = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            g_prod = Gs[j];
            for (int k = j + 1; k < WIDTH; k++) g_prod = g_prod & Ps[k];
            g_sop = g_sop | g_prod;
        end
        GG = g_sop;
        PG = &Ps;
    end
`endif

endmodule

// File: rtl/cla_block_8.sv
// Registered carry-lookahead adder slice: S/Cout = A + B + Cin, one cycle latency.
// Define CLA_GROUP_PG_EN to add registered group generate/propagate outputs GG/PG.
module cla_block_8
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [WIDTH-1:0] Gs,
    input  logic [WIDTH-1:0] Ps,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef CLA_GROUP_PG_EN
    ,
    output logic             GG,
    output logic             PG
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;

`ifdef CLA_GROUP_PG_EN
    logic gg_d, gg_q;
    logic pg_d, pg_q;
`endif

    cla_carry_net #(.WIDTH(WIDTH)) u_carry (
        .Gs  (Gs),
        .Ps  (Ps),
        .Cin (Cin),
        .C   (c)
`ifdef CLA_GROUP_PG_EN
        ,
        .GG  (gg_d),
        .PG  (pg_d)
`endif
    );

    // Sum uses A^B directly so either Ps flavour (A|B or A^B) yields the right result
    assign s_d    = A ^ B ^ c[WIDTH-1:0];
    assign cout_d = c[WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

`ifdef CLA_GROUP_PG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            gg_q <= 1'b0;
            pg_q <= 1'b0;
        end else begin
            gg_q <= gg_d;
            pg_q <= pg_d;
        end
    end

    assign GG = gg_q;
    assign PG = pg_q;
`endif

endmodule

// File: tb/tb_cla_block_8.sv
// Scoreboard bench for cla_block_8: expectations queued at drive time, checked one edge later.
module tb_cla_block_8;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         gg;
        logic         pg;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] A, B, Gs, Ps;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;
`ifdef CLA_GROUP_PG_EN
    logic         GG, PG;
`endif

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clock = ~clock;

    cla_block_8 dut (
        .clock (clock),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Gs    (Gs),
        .Ps    (Ps),
        .S     (S),
        .Cout  (Cout)
`ifdef CLA_GROUP_PG_EN
        ,
        .GG    (GG),
        .PG    (PG)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Group generate reference: ripple the carry from 0 through the supplied Gs/Ps
    function automatic logic ref_gg(input logic [W-1:0] gs, input logic [W-1:0] ps);
        logic cc;
        cc = 1'b0;
        for (int i = 0; i < W; i++) cc = gs[i] | (ps[i] & cc);
        return cc;
    endfunction

    task automatic drv_gp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] gs, input logic [W-1:0] ps,
                          input logic rst);
        exp_t         e;
        logic [W:0]   sum;
        @(negedge clock);
        A = a; B = b; Cin = cin; Gs = gs; Ps = ps; reset = rst;
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        if (rst) e = '0;
        else begin
            e.s    = sum[W-1:0];
            e.cout = sum[W];
            e.gg   = ref_gg(gs, ps);
            e.pg   = &ps;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drv(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit xor_ps, input logic rst);
        drv_gp(tag, a, b, cin, a & b, xor_ps ? (a ^ b) : (a | b), rst);
    endtask

    always @(posedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            #1;
            chk({t, ".S"}, 32'(S), 32'(e.s));
            chk({t, ".Cout"}, 32'(Cout), 32'(e.cout));
`ifdef CLA_GROUP_PG_EN
            chk({t, ".GG"}, 32'(GG), 32'(e.gg));
            chk({t, ".PG"}, 32'(PG), 32'(e.pg));
`endif
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic         ci;
        reset = 1'b1; A = '0; B = '0; Cin = 1'b0; Gs = '0; Ps = '0;

        drv("rst0", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        drv("rst1", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        drv("post_rst", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        drv("zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drv("prop_wrap", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        drv("gen_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        drv("gen_00_ff", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        drv("all1_cin", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset drops the in-flight result
        drv("pre_mid", 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
        drv("mid_rst", 8'h77, 8'h11, 1'b1, 1'b0, 1'b1);
        drv("after_mid", 8'h77, 8'h11, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            a  = k[0] ? 8'hA5 : 8'h3F;
            b  = k[1] ? 8'hC3 : 8'h81;
            ci = k[2];
            drv("pipe", a, b, ci, 1'b0, 1'b0);
        end

        for (int n = 0; n < 10000; n++)
            drv("rand_or", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        for (int n = 0; n < 2000; n++)
            drv("rand_xor", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);

        drv_gp("grp_prop", 8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0);
        drv_gp("grp_gen", 8'h80, 8'h80, 1'b0, 8'h80, 8'h80, 1'b0);

        @(negedge clock);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
